// File: rtl/pwm_wave_gen_if.sv
// Control and sample/PWM signals of the self-test waveform source.
// The controller drives the master side; the generator is the slave.
interface pwm_wave_gen_if;
  logic        enable;
  logic [1:0]  wave_sel;
  logic [15:0] freq_step;
  logic        pwm_out;
  logic [15:0] sample;
  logic        sample_valid;

  modport master (
    output enable,
    output wave_sel,
    output freq_step,
    input  pwm_out,
    input  sample,
    input  sample_valid
  );

  modport slave (
    input  enable,
    input  wave_sel,
    input  freq_step,
    output pwm_out,
    output sample,
    output sample_valid
  );
endinterface

// File: rtl/pwm_wave_gen.sv
// Test-waveform generator: a phase accumulator feeds a square/saw/triangle/DC
// shaper, and the top bits of each sample set the duty of a registered PWM pin.
module pwm_wave_gen #(
  parameter int PWM_BITS   = 8,
  parameter int PHASE_BITS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  pwm_wave_gen_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
  localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

  localparam logic [1:0] SEL_SQUARE = 2'b00;
  localparam logic [1:0] SEL_SAW    = 2'b01;
  localparam logic [1:0] SEL_TRI    = 2'b10;

  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic [15:0]           sample_q, sample_d;
  logic                  vld_q, vld_d;
  logic                  pwm_q, pwm_d;
  logic                  upd;
  logic [15:0]           wave;

  // Triangle folds the upper half of the phase back down so the ramp is continuous.
  function automatic logic [15:0] wave_f(input logic [15:0] p, input logic [1:0] sel);
    logic [15:0] dbl;
    dbl = {p[14:0], 1'b0};
    case (sel)
      SEL_SQUARE: wave_f = p[15] ? 16'h0000 : 16'hFFFF;
      SEL_SAW:    wave_f = p;
      SEL_TRI:    wave_f = p[15] ? ~dbl : dbl;
      default:    wave_f = 16'h8000;
    endcase
  endfunction

  assign upd  = bus.enable && (cnt_q == CNT_LAST);
  assign wave = wave_f(phase_q, bus.wave_sel);

  always_comb begin
    cnt_d    = '0;
    duty_d   = '0;
    phase_d  = '0;
    sample_d = '0;
    vld_d    = 1'b0;
    pwm_d    = 1'b0;
    if (bus.enable) begin
      cnt_d    = cnt_q + CNT_ONE;
      duty_d   = duty_q;
      phase_d  = phase_q;
      sample_d = sample_q;
      // Compare against the registered duty so a new sample only affects the next period.
      pwm_d    = (cnt_q < duty_q);
      if (upd) begin
        sample_d = wave;
        duty_d   = wave[15 -: PWM_BITS];
        phase_d  = phase_q + bus.freq_step;
        vld_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      duty_q   <= '0;
      phase_q  <= '0;
      sample_q <= '0;
      vld_q    <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      vld_q    <= vld_d;
      pwm_q    <= pwm_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = vld_q;

endmodule

// File: tb/tb_pwm_wave_gen.sv
// Directed bench for pwm_wave_gen: table of per-update expected samples and
// PWM high counts, plus hand sequences for reset, config timing and enable drop.
module tb_pwm_wave_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_wave_gen_if bus ();

  pwm_wave_gen #(.PWM_BITS(8), .PHASE_BITS(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit          restart;
    logic [1:0]  ws;
    logic [15:0] step;
    logic [15:0] exp_s;
    int          exp_high;
  } vec_t;

  vec_t vt[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    while (bus.sample_valid !== 1'b1 && n < 300) begin
      step();
      n++;
    end
  endtask

  // Counts pwm_out highs over one full period and where the next sample_valid lands.
  task automatic count_period(output int hi, output int vat);
    hi = 0;
    vat = -1;
    for (int i = 0; i < 256; i++) begin
      step();
      if (bus.pwm_out === 1'b1) hi++;
      if (bus.sample_valid === 1'b1 && vat < 0) vat = i;
    end
  endtask

  task automatic restart(input logic [1:0] ws, input logic [15:0] st);
    int n;
    bus.enable = 1'b0;
    bus.wave_sel = ws;
    bus.freq_step = st;
    step();
    check("cleared_outputs", {bus.pwm_out, bus.sample_valid, bus.sample}, 18'h0);
    bus.enable = 1'b1;
    wait_vld(n);
    check("first_vld_latency", n, 256);
  endtask

  task automatic measure(input vec_t v, input int idx);
    int n, hi, vat;
    wait_vld(n);
    if (n >= 300) begin
      check($sformatf("vld_timeout[%0d]", idx), 0, 1);
      return;
    end
    check($sformatf("sample[%0d]", idx), bus.sample, v.exp_s);
    count_period(hi, vat);
    check($sformatf("high[%0d]", idx), hi, v.exp_high);
    check($sformatf("spacing[%0d]", idx), vat, 255);
  endtask

  function automatic void push(input bit r, input logic [1:0] ws, input logic [15:0] st,
                               input logic [15:0] s, input int hi);
    vec_t v;
    v.restart = r; v.ws = ws; v.step = st; v.exp_s = s; v.exp_high = hi;
    vt.push_back(v);
  endfunction

  initial begin
    int n, hi, vat;
    logic [15:0] tri_s [9];

    // Sawtooth, step 0x1000: 0x0000..0xF000 then wrap; high count = sample[15:8].
    for (int k = 0; k < 17; k++)
      push(k == 0, 2'b01, 16'h1000, 16'((k % 16) * 16'h1000), (k % 16) * 16);
    // Triangle, step 0x2000.
    tri_s = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF,
              16'hBFFF, 16'h7FFF, 16'h3FFF, 16'h0000};
    for (int k = 0; k < 9; k++)
      push(k == 0, 2'b10, 16'h2000, tri_s[k], int'(tri_s[k][15:8]));
    // Square, step 0x8000: alternates full-scale and zero.
    push(1'b1, 2'b00, 16'h8000, 16'hFFFF, 255);
    push(1'b0, 2'b00, 16'h8000, 16'h0000, 0);
    push(1'b0, 2'b00, 16'h8000, 16'hFFFF, 255);
    // DC ignores phase.
    push(1'b1, 2'b11, 16'h1234, 16'h8000, 128);
    push(1'b0, 2'b11, 16'h1234, 16'h8000, 128);
    // Zero step: square stays on its phase-0 value.
    push(1'b1, 2'b00, 16'h0000, 16'hFFFF, 255);
    push(1'b0, 2'b00, 16'h0000, 16'hFFFF, 255);

    bus.enable = 1'b0;
    bus.wave_sel = 2'b00;
    bus.freq_step = 16'h0;
    #1;
    check("reset_outputs", {bus.pwm_out, bus.sample_valid, bus.sample}, 18'h0);
    #10;
    rst_n = 1'b1;
    step();

    foreach (vt[i]) begin
      if (vt[i].restart) restart(vt[i].ws, vt[i].step);
      measure(vt[i], i);
    end

    // Asynchronous reset while pwm_out is high.
    restart(2'b00, 16'h0000);
    for (int i = 0; i < 10; i++) step();
    check("pwm_high_before_reset", bus.pwm_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {bus.pwm_out, bus.sample_valid, bus.sample}, 18'h0);
    bus.wave_sel = 2'b01;
    bus.freq_step = 16'h1000;
    bus.enable = 1'b1;
    #2;
    rst_n = 1'b1;
    wait_vld(n);
    check("post_reset_vld_latency", n, 256);
    check("post_reset_sample", bus.sample, 16'h0000);

    // Step change mid-period: W uses the old phase, new step applies at that update.
    count_period(hi, vat);
    check("cfg_sample_1000", bus.sample, 16'h1000);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (i == 99) bus.freq_step = 16'h4000;
      if (bus.pwm_out === 1'b1) hi++;
    end
    check("cfg_high_unchanged", hi, 16);
    check("cfg_sample_old_phase", bus.sample, 16'h2000);
    count_period(hi, vat);
    check("cfg_high_2000", hi, 32);
    check("cfg_sample_new_step", bus.sample, 16'h6000);

    // Enable drop at cnt=50.
    for (int i = 0; i < 50; i++) step();
    check("cnt_before_drop", dut.cnt_q, 50);
    bus.enable = 1'b0;
    step();
    check("drop_outputs", {bus.pwm_out, bus.sample_valid, bus.sample}, 18'h0);
    check("drop_cnt_phase", {dut.cnt_q, dut.phase_q}, 24'h0);
    vat = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.sample_valid !== 1'b0) vat++;
    end
    check("no_vld_while_idle", vat, 0);
    bus.enable = 1'b1;
    wait_vld(n);
    check("reenable_vld_latency", n, 256);
    check("reenable_sample0", bus.sample, 16'h0000);
    count_period(hi, vat);
    check("reenable_sample1", bus.sample, 16'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_wave_gen.md
Name: pwm_wave_gen

Overview:
- Self-test stimulus source: the transmit side of the analog capture path.
- Generates a periodic test waveform (square, sawtooth, triangle, midscale DC) as 16-bit samples from a phase accumulator.
- Drives the waveform out on one pin as PWM; an external RC filter on the pin is looped back into an XADC aux input.
- The scope display then shows a known trace for calibration and bring-up.

Parameters:
- PWM_BITS, 8: PWM resolution. Period is 2^PWM_BITS clk cycles; duty is sample[15:16-PWM_BITS].
- PHASE_BITS, 16: phase accumulator width. Fixed at 16 so that phase maps 1:1 onto a sample.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  run generator; low = idle/cleared
- wave_sel  input  2  00 square, 01 sawtooth, 10 triangle, 11 DC midscale
- freq_step  input  16  phase increment applied per PWM period
- pwm_out  output  1  registered PWM output to pin
- sample  output  16  waveform value currently being emitted
- sample_valid  output  1  one-cycle pulse when sample/duty update

Behaviour:
Clock and reset:
- One clock, clk; reset is asynchronous and active-low (rst_n). All state is on clk.

Reset values (rst_n low, immediate and asynchronous):
- cnt = 0, phase = 0, duty = 0
- sample = 0, sample_valid = 0, pwm_out = 0

Registers:
- cnt: PWM_BITS-bit counter.
- phase: 16-bit accumulator.
- duty: PWM_BITS bits.
- sample: 16 bits.

enable low (synchronous clear on next edge):
- cnt <= 0, phase <= 0, duty <= 0, sample <= 0.
- pwm_out <= 0, sample_valid <= 0.

enable high:
- cnt increments every cycle and wraps from 2^PWM_BITS-1 to 0.

Update cycle (enable high and cnt == 2^PWM_BITS-1):
- W = wave(phase, wave_sel), computed from the current (pre-increment) phase:
  - 00 square: phase[15] ? 16'h0000 : 16'hFFFF
  - 01 sawtooth: phase
  - 10 triangle: phase[15] ? ~(phase<<1) : (phase<<1), truncated to 16 bits
  - 11 DC: 16'h8000
- sample <= W; duty <= W[15:16-PWM_BITS].
- phase <= phase + freq_step, modulo 2^16; wrap is silent.
- sample_valid <= 1 for exactly one cycle, coincident with cnt == 0.
- wave_sel and freq_step are sampled only on update cycles. Changes between updates take effect at the next update; there is no mid-period glitch.

PWM output:
- Every enabled cycle: pwm_out <= (cnt < duty). This is one cycle of latency vs cnt.
- pwm_out is high exactly duty cycles per period.
- duty 0: constant low. Maximum duty: high 2^PWM_BITS-1 of 2^PWM_BITS cycles, never constant high.

Timing:
- First period after enable rises: duty = 0, so output is low.
- First sample_valid occurs 2^PWM_BITS cycles after enable rises and carries wave(phase 0).
- sample_valid period is 2^PWM_BITS cycles; with defaults, 256 cycles (390.625 kHz).

Boundary cases:
- freq_step = 0: phase is constant and sample is repeated on every update.
- enable dropping mid-period: clear on the next edge; no partial-period completion.
- rst_n asserted mid-period: all outputs go to 0 immediately.
- rst_n release: the first edge after release behaves as enable-dependent normal operation.

Test Plan:
- Reset: rst_n low mid-run with pwm_out high -> pwm_out, sample, sample_valid are 0 with no clock edge. Release with enable=1 -> first sample_valid exactly 256 cycles later, sample=0x0000.
- Sawtooth: wave_sel=01, freq_step=0x1000 -> samples 0x0000, 0x1000, …, 0xF000, then 0x0000 (wrap). In the period following sample 0x1000, pwm_out is high for exactly 16 cycles. sample_valid spacing is 256 cycles.
- Triangle: wave_sel=10, freq_step=0x2000 -> samples 0x0000, 0x4000, 0x8000, 0xC000, 0xFFFF, 0xBFFF, 0x7FFF, 0x3FFF, then repeats.
- Square/DC: wave_sel=00, step=0x8000 -> samples alternate 0xFFFF / 0x0000; pwm_out high 255 of 256 cycles, then 0 cycles. wave_sel=11 -> sample 0x8000, 128 high cycles per period.
- Config timing: change freq_step from 0x1000 to 0x4000 at cnt=100 -> the next update still uses the old phase for W; the step applied on that update is 0x4000. No change in pwm_out within the current period.
- Enable: drop enable at cnt=50 -> next cycle cnt=0, phase=0, pwm_out=0, no sample_valid. Re-enable -> the sequence restarts from sample 0x0000 after 256 cycles.
